// File: rtl/systolic_mac_cell.sv
// Systolic tile: nibble-serial column/row links feeding a DIMxDIM integer accumulator block.
// Each frame is forwarded downstream or used to MAC into, clear, or drain the local accumulators.
module systolic_mac_cell #(
  parameter int unsigned DIM    = 2,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned NIB    = 4,
  parameter int unsigned SAT    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [NIB-1:0] col_in,
  input  logic           col_ctrl_in,
  input  logic [NIB-1:0] row_in,
  input  logic           row_ctrl_in,
  output logic [NIB-1:0] col_out,
  output logic           col_ctrl_out,
  output logic [NIB-1:0] row_out,
  output logic           row_ctrl_out,
  output logic           frame_start
);
  localparam int unsigned W     = DIM * ELEM_W;
  localparam int unsigned FRAME = W / NIB;
  localparam int unsigned ACC_W = 2 * ELEM_W;
  localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned PH_W  = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int unsigned HALF  = DIM / 2;

  if ((DIM < 2) || ((DIM % 2) != 0) || ((FRAME * NIB) != W) || ((DIM * DIM) > FRAME) ||
      (FRAME < 2) || (FRAME < IDX_W)) begin : g_param_check
    $error("systolic_mac_cell: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_MAC   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_DRAIN = 2'b11
  } op_e;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [W-NIB-1:0]  col_buf_q, col_buf_d, row_buf_q, row_buf_d;
  logic [FRAME-2:0]  cctl_buf_q, cctl_buf_d, rctl_buf_q, rctl_buf_d;
  logic [W-1:0]      col_osr_q, col_osr_d, row_osr_q, row_osr_d;
  logic [FRAME-1:0]  cctl_osr_q, cctl_osr_d, rctl_osr_q, rctl_osr_d;
  logic [ACC_W-1:0]  acc_q [DIM][DIM];
  logic [ACC_W-1:0]  acc_d [DIM][DIM];
  logic [ELEM_W-1:0] a_q [DIM];
  logic [ELEM_W-1:0] a_d [DIM];
  logic [ELEM_W-1:0] b_q [DIM];
  logic [ELEM_W-1:0] b_d [DIM];
  logic              mac_busy_q, mac_busy_d;
  logic [IDX_W-1:0]  mac_i_q, mac_i_d, mac_j_q, mac_j_d;

  logic              latch;
  logic [W-1:0]      col_frame, row_frame;
  logic [FRAME-1:0]  cctl_frame, rctl_frame;
  op_e               op;
  logic [IDX_W-1:0]  drain_r;
  logic              mac_last;
  logic [ELEM_W-1:0] a_sel, b_sel;
  logic [ACC_W-1:0]  acc_sel, prod, sum_sat;
  logic [ACC_W:0]    sum;
  logic              ovf;

  // Full frame at the latch edge is the buffered digits plus the live one
  assign latch      = (phase_q == PH_W'(FRAME - 1));
  assign col_frame  = {col_buf_q, col_in};
  assign row_frame  = {row_buf_q, row_in};
  assign cctl_frame = {cctl_buf_q, col_ctrl_in};
  assign rctl_frame = {rctl_buf_q, row_ctrl_in};
  assign op         = op_e'(cctl_frame[FRAME-1 -: 2]);
  assign drain_r    = rctl_frame[FRAME-1 -: IDX_W];
  assign mac_last   = (mac_i_q == IDX_W'(DIM - 1)) && (mac_j_q == IDX_W'(DIM - 1));

  // Low ACC_W bits of the product of sign-extended operands are the signed product
  assign a_sel   = a_q[mac_i_q];
  assign b_sel   = b_q[mac_j_q];
  assign acc_sel = acc_q[mac_i_q][mac_j_q];
  assign prod    = {{ELEM_W{a_sel[ELEM_W-1]}}, a_sel} * {{ELEM_W{b_sel[ELEM_W-1]}}, b_sel};
  assign sum     = {acc_sel[ACC_W-1], acc_sel} + {prod[ACC_W-1], prod};
  assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
  assign sum_sat = ((SAT != 0) && ovf) ?
                   (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                   sum[ACC_W-1:0];

  always_comb begin
    phase_d    = phase_q;
    col_buf_d  = col_buf_q;
    row_buf_d  = row_buf_q;
    cctl_buf_d = cctl_buf_q;
    rctl_buf_d = rctl_buf_q;
    col_osr_d  = col_osr_q;
    row_osr_d  = row_osr_q;
    cctl_osr_d = cctl_osr_q;
    rctl_osr_d = rctl_osr_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    mac_busy_d = mac_busy_q;
    mac_i_d    = mac_i_q;
    mac_j_d    = mac_j_q;
    if (ena) begin
      phase_d    = latch ? '0 : phase_q + PH_W'(1);
      col_buf_d  = col_frame[W-NIB-1:0];
      row_buf_d  = row_frame[W-NIB-1:0];
      cctl_buf_d = cctl_frame[FRAME-2:0];
      rctl_buf_d = rctl_frame[FRAME-2:0];
      col_osr_d  = {col_osr_q[W-NIB-1:0], {NIB{1'b0}}};
      row_osr_d  = {row_osr_q[W-NIB-1:0], {NIB{1'b0}}};
      cctl_osr_d = {cctl_osr_q[FRAME-2:0], 1'b0};
      rctl_osr_d = {rctl_osr_q[FRAME-2:0], 1'b0};
      // Engine walks (i,j) row-major; written first so a same-edge drain sees it and clear wins
      if (mac_busy_q) begin
        acc_d[mac_i_q][mac_j_q] = sum_sat;
        if (mac_last) begin
          mac_busy_d = 1'b0;
        end else if (mac_j_q == IDX_W'(DIM - 1)) begin
          mac_j_d = '0;
          mac_i_d = mac_i_q + IDX_W'(1);
        end else begin
          mac_j_d = mac_j_q + IDX_W'(1);
        end
      end
      if (latch) begin
        col_osr_d  = col_frame;
        row_osr_d  = row_frame;
        cctl_osr_d = cctl_frame;
        rctl_osr_d = rctl_frame;
        case (op)
          OP_MAC: begin
            for (int k = 0; k < DIM; k++) begin
              a_d[k] = col_frame[(DIM-k)*ELEM_W-1 -: ELEM_W];
              b_d[k] = row_frame[(DIM-k)*ELEM_W-1 -: ELEM_W];
            end
            mac_busy_d = 1'b1;
            mac_i_d    = '0;
            mac_j_d    = '0;
          end
          OP_CLEAR: begin
            for (int i = 0; i < DIM; i++) begin
              for (int j = 0; j < DIM; j++) acc_d[i][j] = '0;
            end
          end
          OP_DRAIN: begin
            col_osr_d = '0;
            row_osr_d = '0;
            for (int r = 0; r < DIM; r++) begin
              if (drain_r == IDX_W'(r)) begin
                for (int j = 0; j < HALF; j++) begin
                  col_osr_d[W-1-j*ACC_W -: ACC_W] = acc_d[r][j];
                  row_osr_d[W-1-j*ACC_W -: ACC_W] = acc_d[r][HALF+j];
                end
              end
            end
            cctl_osr_d[FRAME-1 -: 2] = 2'b00;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      col_buf_q  <= '0;
      row_buf_q  <= '0;
      cctl_buf_q <= '0;
      rctl_buf_q <= '0;
      col_osr_q  <= '0;
      row_osr_q  <= '0;
      cctl_osr_q <= '0;
      rctl_osr_q <= '0;
      mac_busy_q <= 1'b0;
      mac_i_q    <= '0;
      mac_j_q    <= '0;
      for (int i = 0; i < DIM; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        for (int j = 0; j < DIM; j++) acc_q[i][j] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      col_buf_q  <= col_buf_d;
      row_buf_q  <= row_buf_d;
      cctl_buf_q <= cctl_buf_d;
      rctl_buf_q <= rctl_buf_d;
      col_osr_q  <= col_osr_d;
      row_osr_q  <= row_osr_d;
      cctl_osr_q <= cctl_osr_d;
      rctl_osr_q <= rctl_osr_d;
      mac_busy_q <= mac_busy_d;
      mac_i_q    <= mac_i_d;
      mac_j_q    <= mac_j_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign col_out      = col_osr_q[W-1 -: NIB];
  assign row_out      = row_osr_q[W-1 -: NIB];
  assign col_ctrl_out = cctl_osr_q[FRAME-1];
  assign row_ctrl_out = rctl_osr_q[FRAME-1];
  // Gated so the pulse stays low while reset is held
  assign frame_start  = ~rst & (phase_q == '0);

endmodule

// File: tb/tb_systolic_mac_cell.sv
// Directed bench for systolic_mac_cell: saturating and wrapping tiles share stimulus and are
// checked digit by digit against a frame-level accumulator model through a scoreboard queue.
module tb_systolic_mac_cell;
  localparam int unsigned DIM    = 2;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned NIB    = 4;
  localparam int unsigned FRAME  = 4;
  localparam int unsigned W      = DIM * ELEM_W;
  localparam int unsigned IDX_W  = 1;

  logic           clk = 1'b0;
  logic           rst, ena;
  logic [NIB-1:0] col_in, row_in;
  logic           col_ctrl_in, row_ctrl_in;
  logic [NIB-1:0] col_out_s, row_out_s, col_out_w, row_out_w;
  logic           col_ctrl_out_s, row_ctrl_out_s, col_ctrl_out_w, row_ctrl_out_w;
  logic           fs_s, fs_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]     cd;
    logic [W-1:0]     rd;
    logic [W-1:0]     cd_w;
    logic [W-1:0]     rd_w;
    logic [FRAME-1:0] cc;
    logic [FRAME-1:0] rc;
  } exp_t;

  exp_t sb[$];
  int   acc_s [DIM][DIM];
  int   acc_w [DIM][DIM];

  always #5 clk = ~clk;

  systolic_mac_cell #(.DIM(DIM), .ELEM_W(ELEM_W), .NIB(NIB), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .ena(ena),
    .col_in(col_in), .col_ctrl_in(col_ctrl_in), .row_in(row_in), .row_ctrl_in(row_ctrl_in),
    .col_out(col_out_s), .col_ctrl_out(col_ctrl_out_s), .row_out(row_out_s),
    .row_ctrl_out(row_ctrl_out_s), .frame_start(fs_s)
  );

  systolic_mac_cell #(.DIM(DIM), .ELEM_W(ELEM_W), .NIB(NIB), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .ena(ena),
    .col_in(col_in), .col_ctrl_in(col_ctrl_in), .row_in(row_in), .row_ctrl_in(row_ctrl_in),
    .col_out(col_out_w), .col_ctrl_out(col_ctrl_out_w), .row_out(row_out_w),
    .row_ctrl_out(row_ctrl_out_w), .frame_start(fs_w)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  function automatic int elem(input logic [W-1:0] x, input int k);
    logic signed [ELEM_W-1:0] e;
    e = x[(DIM-k)*ELEM_W-1 -: ELEM_W];
    return int'(e);
  endfunction

  function automatic exp_t zero_exp();
    exp_t z;
    z.cd = '0; z.rd = '0; z.cd_w = '0; z.rd_w = '0; z.cc = '0; z.rc = '0;
    return z;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        acc_s[i][j] = 0;
        acc_w[i][j] = 0;
      end
    sb.delete();
    sb.push_back(zero_exp());
  endfunction

  // Frame-level model: a MAC frame's products are complete before the next frame's op
  function automatic exp_t model_frame(input logic [W-1:0] cd, input logic [W-1:0] rd,
                                       input logic [FRAME-1:0] cc, input logic [FRAME-1:0] rc);
    exp_t n;
    int   r, p;
    n.cd = cd; n.rd = rd; n.cd_w = cd; n.rd_w = rd; n.cc = cc; n.rc = rc;
    case (cc[FRAME-1 -: 2])
      2'b01: begin
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            p = elem(cd, i) * elem(rd, j);
            acc_s[i][j] = clamp16(acc_s[i][j] + p);
            acc_w[i][j] = wrap16(acc_w[i][j] + p);
          end
      end
      2'b10: begin
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) begin
            acc_s[i][j] = 0;
            acc_w[i][j] = 0;
          end
      end
      2'b11: begin
        r = int'(rc[FRAME-1 -: IDX_W]);
        n.cd = '0; n.rd = '0; n.cd_w = '0; n.rd_w = '0;
        if (r < DIM) begin
          for (int j = 0; j < DIM / 2; j++) begin
            n.cd[W-1-j*16 -: 16]   = 16'(acc_s[r][j]);
            n.rd[W-1-j*16 -: 16]   = 16'(acc_s[r][DIM/2+j]);
            n.cd_w[W-1-j*16 -: 16] = 16'(acc_w[r][j]);
            n.rd_w[W-1-j*16 -: 16] = 16'(acc_w[r][DIM/2+j]);
          end
        end
        n.cc[FRAME-1 -: 2] = 2'b00;
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic rand_inputs();
    col_in      = 4'($urandom);
    row_in      = 4'($urandom);
    col_ctrl_in = 1'($urandom);
    row_ctrl_in = 1'($urandom);
  endtask

  task automatic check_digit(input exp_t e, input int p, input string tag);
    int hi;
    hi = W - 1 - p * NIB;
    chk($sformatf("%s_sat_p%0d", tag, p),
        16'({col_out_s, col_ctrl_out_s, row_out_s, row_ctrl_out_s, fs_s}),
        16'({e.cd[hi -: NIB], e.cc[FRAME-1-p], e.rd[hi -: NIB], e.rc[FRAME-1-p], p == 0}));
    chk($sformatf("%s_wrap_p%0d", tag, p),
        16'({col_out_w, col_ctrl_out_w, row_out_w, row_ctrl_out_w, fs_w}),
        16'({e.cd_w[hi -: NIB], e.cc[FRAME-1-p], e.rd_w[hi -: NIB], e.rc[FRAME-1-p], p == 0}));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sat"}, 16'({col_out_s, col_ctrl_out_s, row_out_s, row_ctrl_out_s, fs_s}), 16'h0);
    chk({tag, "_wrap"}, 16'({col_out_w, col_ctrl_out_w, row_out_w, row_ctrl_out_w, fs_w}), 16'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      rand_inputs();
      @(posedge clk);
      @(negedge clk);
      check_zero("reset");
    end
    rst = 1'b0;
    ena = 1'b1;
    #1;
    model_reset();
  endtask

  // Drives one frame while checking the previous frame's output digits
  task automatic run_frame(input string tag, input logic [W-1:0] cd, input logic [FRAME-1:0] cc,
                           input logic [W-1:0] rd, input logic [FRAME-1:0] rc,
                           input int stall_at = -1, input int rst_at = -1);
    exp_t e, n;
    e = sb.pop_front();
    n = model_frame(cd, rd, cc, rc);
    for (int p = 0; p < FRAME; p++) begin
      check_digit(e, p, tag);
      if (p == rst_at) begin
        rst = 1'b1;
        rand_inputs();
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, "_rst"});
        rst = 1'b0;
        #1;
        model_reset();
        return;
      end
      if (p == stall_at) begin
        ena = 1'b0;
        repeat (5) begin
          rand_inputs();
          @(posedge clk);
          @(negedge clk);
          check_digit(e, p, {tag, "_stall"});
        end
        ena = 1'b1;
      end
      col_in      = cd[W-1-p*NIB -: NIB];
      row_in      = rd[W-1-p*NIB -: NIB];
      col_ctrl_in = cc[FRAME-1-p];
      row_ctrl_in = rc[FRAME-1-p];
      @(posedge clk);
      @(negedge clk);
    end
    sb.push_back(n);
  endtask

  initial begin
    #1000000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]     rcd, rrd;
    logic [FRAME-1:0] rcc, rrc;
    rst = 1'b1;
    ena = 1'b1;
    rand_inputs();
    do_reset(3);

    run_frame("idle", 16'hA5C3, 4'b0011, 16'h1234, 4'b0011);

    run_frame("clear_a", 16'h0000, 4'b1000, 16'h0000, 4'b0000);
    run_frame("mac_a", 16'h03FE, 4'b0100, 16'h0507, 4'b0000);
    run_frame("drain0_a", 16'hFFFF, 4'b1100, 16'hEEEE, 4'b0000);
    run_frame("drain1_a", 16'h5555, 4'b1111, 16'hAAAA, 4'b1010);

    run_frame("clear_s", 16'h1234, 4'b1001, 16'h5678, 4'b0110);
    run_frame("mac_s1", 16'h7F7F, 4'b0100, 16'h7F7F, 4'b0000);
    run_frame("mac_s2", 16'h7F7F, 4'b0101, 16'h7F7F, 4'b0001);
    run_frame("mac_s3", 16'h7F7F, 4'b0110, 16'h7F7F, 4'b0010);
    run_frame("drain0_s", 16'h0000, 4'b1100, 16'h0000, 4'b0000);
    run_frame("drain1_s", 16'h0000, 4'b1100, 16'h0000, 4'b1000);

    run_frame("clear_b", 16'h0000, 4'b1000, 16'h0000, 4'b0000);
    run_frame("mac_b", 16'h807F, 4'b0100, 16'h80FF, 4'b0000);
    run_frame("drain1_b", 16'h0000, 4'b1100, 16'h0000, 4'b1000);
    run_frame("drain0_b", 16'h0000, 4'b1100, 16'h0000, 4'b0000);
    run_frame("mac_c", 16'h1122, 4'b0100, 16'h3344, 4'b0000);
    run_frame("clear_c", 16'h0000, 4'b1000, 16'h0000, 4'b0000);
    run_frame("drain0_c", 16'h0000, 4'b1100, 16'h0000, 4'b0000);
    run_frame("drain1_c", 16'h0000, 4'b1100, 16'h0000, 4'b1000);

    run_frame("clear_st", 16'h0000, 4'b1000, 16'h0000, 4'b0000);
    run_frame("mac_st", 16'h03FE, 4'b0100, 16'h0507, 4'b0000, 2);
    run_frame("drain1_st", 16'h0000, 4'b1100, 16'h0000, 4'b1000, 1);
    run_frame("drain0_st", 16'h0000, 4'b1100, 16'h0000, 4'b0000);

    run_frame("mac_r", 16'h7F7F, 4'b0100, 16'h7F7F, 4'b0000);
    run_frame("idle_r", 16'h0000, 4'b0000, 16'h0000, 4'b0000, -1, 1);
    run_frame("drain0_r", 16'h0000, 4'b1100, 16'h0000, 4'b0000);
    run_frame("drain1_r", 16'h0000, 4'b1100, 16'h0000, 4'b1000);

    for (int f = 0; f < 24; f++) begin
      rcd = 16'($urandom);
      rrd = 16'($urandom);
      rcc = 4'($urandom);
      rrc = 4'($urandom);
      run_frame($sformatf("rand%0d", f), rcd, rcc, rrd, rrc);
    end

    run_frame("flush", 16'h0000, 4'b0000, 16'h0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
